pipe_exe_muldiv: RTL and testbench

- Iterative multiply/divide unit in the EXE stage. It produces the HI/LO results that MFHI/MFLO forward into the EXE/MEM register, and from there into the MEM-stage ALU-result path.
- Executes MULT, MULTU, DIV and DIVU over 34 cycles.
- Holds the architectural HI/LO registers and raises a stall to freeze IF/ID/EXE while a result is pending.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/muldiv_iter.sv | 62 ++++++
 rtl/pipe_exe_muldiv.sv | 160 ++++++++++++++++
 tb/tb_pipe_exe_muldiv.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the EXE-stage multiply/divide unit:
// op encodings, FSM states and iteration count.
package pipe_pkg;

    localparam int ITER = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Single-step datapath: shift-add multiply or restoring
// shift-subtract divide on one 2*WIDTH accumulator.
module muldiv_iter
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = pipe_pkg::ITER
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);

    localparam int CW = $clog2(STEPS);

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shl_rem;
    logic [WIDTH-1:0]   sub_diff;
    logic               sub_ok;
    logic [2*WIDTH-1:0] acc_mul;
    logic [2*WIDTH-1:0] acc_div;

    // mul: acc = {partial, multiplier}; div: acc = {remainder, quotient}
    always_comb begin
        add_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
        acc_mul  = {add_sum, acc[WIDTH-1:1]};
        shl_rem  = acc[2*WIDTH-1:WIDTH-1];
        sub_ok   = shl_rem >= {1'b0, opnd};
        sub_diff = shl_rem[WIDTH-1:0] - opnd;
        acc_div  = {sub_ok ? sub_diff : shl_rem[WIDTH-1:0],
                    acc[WIDTH-2:0], sub_ok};
    end

    assign last = (cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc  <= '0;
            opnd <= '0;
            cnt  <= '0;
        end else if (load) begin
            acc  <= {{WIDTH{1'b0}}, a};
            opnd <= b;
            cnt  <= CW'(STEPS - 1);
        end else if (step) begin
            acc <= is_div ? acc_div : acc_mul;
            if (!last) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

endmodule

// File: rtl/pipe_exe_muldiv.sv
// EXE-stage iterative MULT/MULTU/DIV/DIVU unit with the
// architectural HI/LO registers and pipeline stall request.
module pipe_exe_muldiv
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = pipe_pkg::ITER
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             flush,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t state;
    state_t state_nx;

    logic               sgn;
    logic               start_ok;
    logic               it_load;
    logic               it_step;
    logic               it_last;
    logic               fix_wr;
    logic               is_div_q;
    logic               sq;
    logic               sr;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sgn      = (op == OP_MULT) | (op == OP_DIV);
        mag_a    = (sgn & a[WIDTH-1]) ? -a : a;
        mag_b    = (sgn & b[WIDTH-1]) ? -b : b;
        start_ok = (state == ST_IDLE) & start & ~flush;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        it_load  = 1'b0;
        it_step  = 1'b0;
        fix_wr   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    it_load  = 1'b1;
                    state_nx = op[1] ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL, ST_DIV: begin
                busy    = 1'b1;
                it_step = 1'b1;
                if (flush) begin
                    state_nx = ST_IDLE;
                end else if (it_last) begin
                    state_nx = ST_FIX;
                end
            end
            ST_FIX: begin
                busy = 1'b1;
                if (flush) begin
                    state_nx = ST_IDLE;
                end else begin
                    fix_wr   = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                done     = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign stall = busy & (start | rd_hilo);

    muldiv_iter #(
        .WIDTH (WIDTH),
        .STEPS (ITER)
    ) u_iter (
        .clock  (clock),
        .reset  (reset),
        .load   (it_load),
        .step   (it_step),
        .is_div (state == ST_DIV),
        .a      (mag_a),
        .b      (mag_b),
        .acc    (acc),
        .last   (it_last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_div_q <= 1'b0;
            sq       <= 1'b0;
            sr       <= 1'b0;
        end else if (start_ok) begin
            is_div_q <= op[1];
            sq       <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            sr       <= sgn & a[WIDTH-1];
        end
    end

    // Sign fix-up on the unsigned magnitude result
    always_comb begin
        prod = sq ? -acc : acc;
        quo  = sq ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = sr ? -acc[2*WIDTH-1:WIDTH]
                  : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (fix_wr) begin
            if (is_div_q) begin
                hi <= rem;
                lo <= quo;
            end else begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end
        end else if (!busy && !start_ok) begin
            if (wr_hi) begin
                hi <= wdata;
            end
            if (wr_lo) begin
                lo <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Self-checking bench for pipe_exe_muldiv: vector table,
// random ops against an arithmetic model, corner sequences.
module tb_pipe_exe_muldiv;
    import pipe_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        rd_hilo;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] wdata;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pipe_exe_muldiv dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .op      (op_i),
        .a       (a_i),
        .b       (b_i),
        .rd_hilo (rd_hilo),
        .wr_hi   (wr_hi),
        .wr_lo   (wr_lo),
        .wdata   (wdata),
        .flush   (flush),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h",
                     name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: {hi, lo} from plain 64-bit arithmetic
    function automatic logic [63:0] model(
        input logic [1:0] op, input logic [31:0] a,
        input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            OP_MULTU: res = {32'b0, a} * {32'b0, b};
            OP_MULT:  res = sa * sb;
            OP_DIVU: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else        res = {a % b, a / b};
            end
            default: begin
                if (b == 0) begin
                    res = {a, a[31] ? 32'h1 : 32'hFFFFFFFF};
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
        return res;
    endfunction

    task automatic wait_done(output logic [31:0] rh,
                             output logic [31:0] rl,
                             output int lat,
                             output int busy_n);
        lat    = -1;
        busy_n = 0;
        rh     = '0;
        rl     = '0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                lat = c;
                rh  = hi;
                rl  = lo;
                break;
            end
            if (busy) busy_n++;
            tick();
        end
        tick();
    endtask

    task automatic run_op(input logic [1:0] op,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          output logic [31:0] rh,
                          output logic [31:0] rl,
                          output int lat,
                          output int busy_n);
        op_i  = op;
        a_i   = a;
        b_i   = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(rh, rl, lat, busy_n);
    endtask

    initial begin
        logic [31:0] rh, rl, ra, rb;
        logic [1:0]  rop;
        logic [63:0] exp;
        int lat, bn, sn, sfirst, dn;

        reset   = 1'b1;
        start   = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        rd_hilo = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        wdata   = '0;
        flush   = 1'b0;

        vecs[0] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{OP_MULT, 32'hFFFFFFFD, 32'd7,
                    32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2] = '{OP_DIV, 32'hFFFFFFF9, 32'd2,
                    32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{OP_DIVU, 32'd100, 32'd0,
                    32'd100, 32'hFFFFFFFF};
        vecs[4] = '{OP_DIV, 32'h80000000, 32'hFFFFFFFF,
                    32'h0, 32'h80000000};
        vecs[5] = '{OP_DIV, 32'hFFFFFFFB, 32'd0,
                    32'hFFFFFFFB, 32'h00000001};
        vecs[6] = '{OP_DIV, 32'd5, 32'd0,
                    32'd5, 32'hFFFFFFFF};
        vecs[7] = '{OP_DIVU, 32'd50, 32'd7,
                    32'd1, 32'd7};
        vecs[8] = '{OP_MULT, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h0};
        vecs[9] = '{OP_DIV, 32'd7, 32'hFFFFFFFE,
                    32'd1, 32'hFFFFFFFD};

        #2;
        check("reset_ctl", {61'b0, busy, stall, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        tick();

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b,
                   rh, rl, lat, bn);
            check($sformatf("vec%0d_lat", i), lat, 34);
            check($sformatf("vec%0d_busy", i), bn, 33);
            check($sformatf("vec%0d_hilo", i), {rh, rl},
                  {vecs[i].hi, vecs[i].lo});
        end

        for (int n = 0; n < 50; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: begin ra = 32'h80000000; rb = '1; end
                2: rb = $urandom_range(1, 15);
                3: ra = $urandom_range(0, 15);
                default: ;
            endcase
            exp = model(rop, ra, rb);
            run_op(rop, ra, rb, rh, rl, lat, bn);
            check($sformatf("rand%0d_lat", n), lat, 34);
            check($sformatf("rand%0d_hilo op%0d", n, rop),
                  {rh, rl}, exp);
        end

        // stall while busy on an HI/LO read, clear in DONE
        op_i  = OP_MULTU;
        a_i   = 32'd3;
        b_i   = 32'd5;
        start = 1'b1;
        tick();
        start  = 1'b0;
        sn     = 0;
        sfirst = -1;
        lat    = -1;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) rd_hilo = 1'b1;
            #1;
            if (done) begin
                lat = c;
                check("stall_done", stall, 0);
                check("stall_lo", lo, 15);
                break;
            end
            if (stall) begin
                sn++;
                if (sfirst < 0) sfirst = c;
            end
            tick();
        end
        rd_hilo = 1'b0;
        tick();
        check("stall_lat", lat, 34);
        check("stall_first", sfirst, 5);
        check("stall_cycles", sn, 29);

        // flush mid-divide keeps prior HI/LO
        wr_hi = 1'b1;
        wdata = 32'h1111;
        tick();
        wr_hi = 1'b0;
        wr_lo = 1'b1;
        wdata = 32'h2222;
        tick();
        wr_lo = 1'b0;
        check("mt_hilo", {hi, lo}, {32'h1111, 32'h2222});
        op_i  = OP_DIVU;
        a_i   = 32'd50;
        b_i   = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        dn    = 0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin
                check("flush_busy10", busy, 1);
                flush = 1'b1;
            end
            if (c == 11) begin
                flush = 1'b0;
                check("flush_busy11", busy, 0);
            end
            if (done) dn++;
            tick();
        end
        check("flush_done", dn, 0);
        check("flush_hilo", {hi, lo},
              {32'h1111, 32'h2222});

        // flush in IDLE suppresses start
        op_i  = OP_MULTU;
        a_i   = 32'd9;
        b_i   = 32'd9;
        start = 1'b1;
        flush = 1'b1;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_busy", busy, 0);
        repeat (36) tick();
        check("idle_flush_lo", lo, 32'h2222);

        // start wins over MTHI in the same cycle
        op_i  = OP_MULTU;
        a_i   = 32'd2;
        b_i   = 32'd3;
        start = 1'b1;
        wr_hi = 1'b1;
        wdata = 32'hDEAD;
        tick();
        start = 1'b0;
        wr_hi = 1'b0;
        wait_done(rh, rl, lat, bn);
        check("start_wins_lat", lat, 34);
        check("start_wins_hilo", {rh, rl}, {32'h0, 32'h6});

        // async reset mid-MULT, then MTLO
        wr_hi = 1'b1;
        wdata = 32'h5555;
        tick();
        wr_hi = 1'b0;
        op_i  = OP_MULT;
        a_i   = 32'hFFFFFFFD;
        b_i   = 32'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        check("pre_reset_busy", busy, 1);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        #1;
        reset = 1'b0;
        tick();
        wr_lo = 1'b1;
        wdata = 32'hABCD;
        tick();
        wr_lo = 1'b0;
        check("mtlo_after_rst", {hi, lo},
              {32'h0, 32'hABCD});

        $display("[TB] %0d tests run, %0d failed",
                 tests, fails);
        $finish;
    end

endmodule
